// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in / serial-out transmitter:
// FSM state encoding, the default word width and the bit-counter width rule.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int WIDE_DEFAULT = 4;
    localparam int WIDE_MIN     = 2;
    localparam int WIDE_MAX     = 32;

    // Width of the bit counter: clog2 of the word width, never below one bit.
    function automatic int cnt_width(input int wide);
        return (wide <= 2) ? 1 : $clog2(wide);
    endfunction

endpackage

// File: rtl/piso_hold.sv
// Single-entry holding register. Parks the next word while the current one
// is still being shifted out, so the transmitter can run back-to-back.
module piso_hold
    import piso_pkg::*;
#(
    parameter int WIDE = WIDE_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            wr,
    input  logic            rd,
    input  logic [WIDE-1:0] d,
    output logic [WIDE-1:0] q,
    output logic            full
);

    // Capture a word on wr; release the slot when the shifter takes it on rd.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the data word is cleared as well, so a reset mid-transfer
            // leaves no stale word that could leak out after release.
            q    <= '0;
            full <= 1'b0;
        end else begin
            // NOTE: sequential state always uses <=, so every flop samples the
            // pre-edge value of its neighbours regardless of statement order.
            if (wr) begin
                q <= d;
            end
            if (wr) begin
                full <= 1'b1;
            end else if (rd) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in / serial-out transmitter. Accepts a word on a valid/ready
// handshake and shifts it out one bit per clock on go, qualified by go_valid.
// A one-word holding register (piso_hold) lets the next word follow with no
// idle bit; when the holding slot is empty, a word offered during the last bit
// of the current one bypasses it and goes straight into the shift register.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDE      = WIDE_DEFAULT,
    parameter int MSB_FIRST = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load_valid,
    input  logic [WIDE-1:0] din,
    output logic            load_ready,
    output logic            go,
    output logic            go_valid,
    output logic            word_done,
    output logic            busy
);

    localparam int            CW       = cnt_width(WIDE);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDE - 1);

    if (WIDE < WIDE_MIN || WIDE > WIDE_MAX) begin : g_bad_wide
        $error("piso_tx: WIDE must lie between 2 and 32");
    end

    state_t          state;
    logic [CW-1:0]   bit_cnt;
    logic [WIDE-1:0] shreg;
    logic [WIDE-1:0] shreg_next;
    logic            head_bit;

    logic [WIDE-1:0] hold_q;
    logic            hold_full;
    logic            hold_wr;
    logic            hold_rd;

    logic            accept;
    logic            last_bit;

    // Handshake and cycle qualifiers, all decoded from registered state.
    // load_ready depends only on hold_full, never on load_valid.
    assign load_ready = ~hold_full;
    assign accept     = load_valid & load_ready;
    assign last_bit   = (state == SHIFT) && (bit_cnt == LAST_CNT);

    // A word accepted mid-word is parked; during the last bit an empty slot
    // means the word bypasses the holding register entirely.
    assign hold_wr = accept && (state == SHIFT) && !last_bit;
    assign hold_rd = last_bit && hold_full;

    // Serial order: pick the outgoing bit and the shifted-down register.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, which
        // keeps the block purely combinational (no latch).
        shreg_next = shreg;
        head_bit   = 1'b0;
        if (MSB_FIRST != 0) begin
            head_bit   = shreg[WIDE-1];
            shreg_next = {shreg[WIDE-2:0], 1'b0};
        end else begin
            head_bit   = shreg[0];
            shreg_next = {1'b0, shreg[WIDE-1:1]};
        end
    end

    // Outputs are decodes of flops only; go is forced low outside SHIFT.
    assign go        = (state == SHIFT) & head_bit;
    assign go_valid  = (state == SHIFT);
    assign word_done = last_bit;
    assign busy      = (state == SHIFT) | hold_full;

    // FSM, shift register and bit counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg   <= din;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        bit_cnt <= '0;
                        if (hold_full) begin
                            // Parked word follows with no gap.
                            shreg <= hold_q;
                        end else if (accept) begin
                            // Bypass: word offered on the last bit goes straight in.
                            shreg <= din;
                        end else begin
                            shreg <= shreg_next;
                            state <= IDLE;
                        end
                    end else begin
                        shreg   <= shreg_next;
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    piso_hold #(
        .WIDE (WIDE)
    ) u_hold (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (hold_wr),
        .rd      (hold_rd),
        .d       (din),
        .q       (hold_q),
        .full    (hold_full)
    );

    // The holding slot is never overwritten while occupied.
    a_no_overwrite: assert property (@(posedge clk) disable iff (!reset_n)
        !(hold_wr && hold_full));

    // A parked word only exists while a word is being shifted.
    a_hold_only_in_shift: assert property (@(posedge clk) disable iff (!reset_n)
        hold_full |-> (state == SHIFT));

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDE, default 4, word width in bits; legal range is 2 to 32.
REQ-002 Parameter MSB_FIRST, default 1; when 1 the serial order is bit WIDE-1 down to bit 0, and when 0 it is bit 0 up to bit WIDE-1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clk.
REQ-005 load_valid  input  1  din holds a word offered for transmission.
REQ-006 din  input  WIDE  parallel word, sampled only on an accepted load.
REQ-007 load_ready  output  1  block can accept a word this cycle.
REQ-008 go  output  1  serial data bit, driven to the matching sipo go input.
REQ-009 go_valid  output  1  go carries a valid data bit this cycle.
REQ-010 word_done  output  1  one-cycle pulse during the last bit of each word.
REQ-011 busy  output  1  state is SHIFT or the holding register is full.

Function
REQ-012 A load SHALL be accepted on a rising edge where load_valid=1 and load_ready=1.
REQ-013 load_ready SHALL equal NOT hold_full and SHALL be a pure register decode, with no combinational path from load_valid.
REQ-014 The FSM SHALL have two states: IDLE and SHIFT.
REQ-015 An accept in IDLE SHALL load the word directly into the shift register, clear bit_cnt to 0 and enter SHIFT; the first bit SHALL appear on go the following cycle (latency 1).
REQ-016 In SHIFT, go SHALL present one bit per cycle in MSB_FIRST order, with go_valid=1 for exactly WIDE consecutive cycles per word.
REQ-017 bit_cnt SHALL be clog2(WIDE) bits wide, SHALL increment every SHIFT cycle, and the cycle with bit_cnt==WIDE-1 SHALL be the last-bit cycle.
REQ-018 An accept in SHIFT SHALL write din to the holding register and set hold_full.
REQ-019 In the last-bit cycle with hold_full=1, the holding register SHALL move to the shift register, hold_full SHALL clear, bit_cnt SHALL go to 0, and the state SHALL remain SHIFT, giving a gapless next word.
REQ-020 In the last-bit cycle with hold_full=0 and an accept, din SHALL load directly into the shift register (holding bypass) with no gap, and the state SHALL remain SHIFT.
REQ-021 In the last-bit cycle with hold_full=0 and no accept, the state SHALL return to IDLE.
REQ-022 word_done SHALL be 1 only in the last-bit cycle.
REQ-023 In IDLE, go SHALL be 0 and go_valid SHALL be 0.
REQ-024 load_valid while load_ready=0 SHALL be ignored; din is not sampled and no state changes.
REQ-025 Throughput SHALL be one word per WIDE cycles sustained, with no idle bit between back-to-back words.

Reset
REQ-026 Assertion of reset_n=0 SHALL immediately force: state=IDLE, bit_cnt=0, shift register=0, holding register=0, hold_full=0.
REQ-027 During reset, outputs SHALL be go=0, go_valid=0, word_done=0, busy=0 and load_ready=1.
REQ-028 Reset mid-word SHALL discard the partial word and any held word; the first accept after release SHALL start a fresh word at bit 0.

Structure
REQ-029 A shared package piso_pkg SHALL hold the state encoding (IDLE=0, SHIFT=1), the WIDE default, and the bit-count width function.
REQ-030 The holding register with hold_full SHALL be one sub-module, piso_hold, with ports clk, reset_n, wr, rd, d, q and full.
REQ-031 The FSM, shift register and bit_cnt SHALL reside in piso_tx.

Verification
REQ-032 WIDE=4, MSB_FIRST=1; after reset, accept din=1011 -> go=1,0,1,1 on the 4 cycles after accept, go_valid=1 throughout, word_done on the 4th, then IDLE.
REQ-033 Accept 1011, then 0110 while shifting -> load_ready=0 after the second accept; go stream 1,0,1,1,0,1,1,0 with no gap; word_done on cycles 4 and 8.
REQ-034 Accept 1100 with load_valid held high and din=0011 asserted during the last bit -> bypass load; go stream 1,1,0,0,0,0,1,1 with no gap.
REQ-035 Holding register full and load_valid=1 with din=1111 -> word not accepted, stream unchanged, load_ready=1 resumes after the hold-to-shift transfer.
REQ-036 reset_n pulled low on the 2nd bit of 1010 with a word held -> outputs zero at once; after release, accept 0001 -> go=0,0,0,1.
REQ-037 MSB_FIRST=0, din=1011 -> go=1,1,0,1; the loopback piso_tx to sipo with WIDE=4 SHALL recover 1011 on get.
